// File: rtl/lpif_ustrm_packer.sv
// rtl/lpif_ustrm_packer.sv - half-flit FIFO and two-slot packer feeding the LPIF ustrm_* channel
//
// Ports:
//   clk_wr, rst_wr_n      clock, asynchronous active-low reset
//   link_up               link online; nothing is launched while low
//   lp_state[3:0]         link state, registered into both ustrm_state nibbles
//   in_valid/in_ready     half-flit handshake from the protocol layer
//   in_data/crc/protid    half-flit payload, CRC and protocol id
//   ustrm_*               registered two-slot upstream word (slot1 high, slot0 low)
//   fifo_count            current FIFO occupancy
//   single_emit_cnt       saturating count of single-slot emissions
module lpif_ustrm_packer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  input  logic                          link_up,
  input  logic [3:0]                    lp_state,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [63:0]                   in_data,
  input  logic [3:0]                    in_crc,
  input  logic [1:0]                    in_protid,
  output logic [7:0]                    ustrm_state,
  output logic [3:0]                    ustrm_protid,
  output logic [127:0]                  ustrm_data,
  output logic [1:0]                    ustrm_dvalid,
  output logic [7:0]                    ustrm_crc,
  output logic [1:0]                    ustrm_crc_valid,
  output logic [1:0]                    ustrm_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   single_emit_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_OFFLINE = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  // Entry layout: {protid[69:68], crc[67:64], data[63:0]}
  logic [69:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n, pops;
  logic          rdy_en;
  logic [1:0]    state, state_n;
  logic [7:0]    hold_cnt, hold_n;
  logic          push, many, pair_ok, emit_pair, emit_single;
  logic [69:0]   head0, head1;
  logic [1:0]    dvalid_q;

  // rdy_en keeps in_ready low while reset is held and for the release cycle.
  assign in_ready = rdy_en && (count < CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign head0    = mem[rd_ptr];
  assign head1    = mem[rd_ptr + AW'(1)];
  assign many     = (count >= CW'(2));
  assign pair_ok  = (head0[69:68] == head1[69:68]);

  always_comb begin
    state_n     = state;
    hold_n      = hold_cnt;
    emit_pair   = 1'b0;
    emit_single = 1'b0;
    if (!link_up) begin
      state_n = S_OFFLINE;
      hold_n  = 8'd0;
    end else begin
      case (state)
        S_OFFLINE: begin
          state_n = S_RUN;
          hold_n  = 8'd0;
        end
        S_RUN: begin
          if (many) begin
            // a protid change never shares a word
            emit_pair   = pair_ok;
            emit_single = !pair_ok;
          end else if (count == CW'(1)) begin
            state_n = S_HOLD;
            hold_n  = 8'd1;
          end
        end
        S_HOLD: begin
          if (many) begin
            emit_pair   = pair_ok;
            emit_single = !pair_ok;
            state_n     = S_RUN;
            hold_n      = 8'd0;
          end else if (hold_cnt == 8'(HOLD_CYCLES)) begin
            emit_single = 1'b1;
            state_n     = S_RUN;
            hold_n      = 8'd0;
          end else begin
            hold_n = hold_cnt + 8'd1;
          end
        end
        default: begin
          state_n = S_OFFLINE;
          hold_n  = 8'd0;
        end
      endcase
    end
  end

  assign pops    = emit_pair ? CW'(2) : (emit_single ? CW'(1) : CW'(0));
  assign count_n = count + CW'(push) - pops;

  // Storage needs no reset: count alone says which entries are live.
  always_ff @(posedge clk_wr) begin
    if (push) mem[wr_ptr] <= {in_protid, in_crc, in_data};
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rdy_en          <= 1'b0;
      state           <= S_OFFLINE;
      hold_cnt        <= 8'd0;
      dvalid_q        <= 2'b00;
      ustrm_data      <= '0;
      ustrm_crc       <= '0;
      ustrm_protid    <= '0;
      ustrm_state     <= '0;
      single_emit_cnt <= '0;
    end else begin
      rdy_en      <= 1'b1;
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= rd_ptr + AW'(pops);
      count       <= count_n;
      state       <= state_n;
      hold_cnt    <= hold_n;
      ustrm_state <= {lp_state, lp_state};
      dvalid_q    <= {emit_pair, emit_pair | emit_single};
      // Payload fields hold between emissions; a single emission touches slot0 only.
      if (emit_pair || emit_single) begin
        ustrm_data[63:0]  <= head0[63:0];
        ustrm_crc[3:0]    <= head0[67:64];
        ustrm_protid[1:0] <= head0[69:68];
      end
      if (emit_pair) begin
        ustrm_data[127:64] <= head1[63:0];
        ustrm_crc[7:4]     <= head1[67:64];
        ustrm_protid[3:2]  <= head1[69:68];
      end
      if (emit_single && single_emit_cnt != 16'hFFFF)
        single_emit_cnt <= single_emit_cnt + 16'd1;
    end
  end

  assign fifo_count      = count;
  assign ustrm_dvalid    = dvalid_q;
  assign ustrm_crc_valid = dvalid_q;
  assign ustrm_valid     = dvalid_q;

endmodule

// File: tb/tb_lpif_ustrm_packer.sv
// tb/tb_lpif_ustrm_packer.sv - self-checking bench for lpif_ustrm_packer
module tb_lpif_ustrm_packer;
  localparam int DEPTH = 8;
  localparam int HOLD  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         link_up = 1'b0;
  logic [3:0]   lp_state = 4'h0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic [3:0]   in_crc = '0;
  logic [1:0]   in_protid = '0;
  logic [7:0]   ustrm_state;
  logic [3:0]   ustrm_protid;
  logic [127:0] ustrm_data;
  logic [1:0]   ustrm_dvalid;
  logic [7:0]   ustrm_crc;
  logic [1:0]   ustrm_crc_valid;
  logic [1:0]   ustrm_valid;
  logic [3:0]   fifo_count;
  logic [15:0]  single_emit_cnt;

  int n_chk = 0;
  int n_err = 0;

  lpif_ustrm_packer #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk_wr(clk), .rst_wr_n(rst_n), .link_up(link_up), .lp_state(lp_state),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_crc(in_crc),
    .in_protid(in_protid), .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid),
    .ustrm_data(ustrm_data), .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc),
    .ustrm_crc_valid(ustrm_crc_valid), .ustrm_valid(ustrm_valid),
    .fifo_count(fifo_count), .single_emit_cnt(single_emit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting half-flits plus the age of a lone head.
  logic [69:0]  q[$];
  bit           online = 0;
  int           age = 0;
  bit           m_ready_en = 0;
  int           npop;
  bit           do_push;
  logic [127:0] exp_data = '0;
  logic [7:0]   exp_crc = '0;
  logic [3:0]   exp_protid = '0;
  logic [1:0]   exp_dvalid = '0;
  logic [7:0]   exp_state = '0;
  logic [15:0]  exp_single = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      online = 0; age = 0; m_ready_en = 0;
      exp_data = '0; exp_crc = '0; exp_protid = '0; exp_dvalid = '0;
      exp_state = '0; exp_single = '0;
    end else begin
      do_push = in_valid && m_ready_en && (q.size() < DEPTH);
      npop = 0;
      if (!link_up) begin
        online = 0; age = 0;
      end else if (!online) begin
        online = 1; age = 0;
      end else if (q.size() >= 2) begin
        npop = (q[0][69:68] == q[1][69:68]) ? 2 : 1;
        age = 0;
      end else if (q.size() == 1) begin
        if (age == HOLD) begin
          npop = 1; age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
      exp_dvalid = (npop == 2) ? 2'b11 : (npop == 1) ? 2'b01 : 2'b00;
      if (npop >= 1) begin
        exp_data[63:0]  = q[0][63:0];
        exp_crc[3:0]    = q[0][67:64];
        exp_protid[1:0] = q[0][69:68];
      end
      if (npop == 2) begin
        exp_data[127:64] = q[1][63:0];
        exp_crc[7:4]     = q[1][67:64];
        exp_protid[3:2]  = q[1][69:68];
      end
      for (int i = 0; i < npop; i++) void'(q.pop_front());
      if (do_push) q.push_back({in_protid, in_crc, in_data});
      if (npop == 1 && exp_single != 16'hFFFF) exp_single++;
      exp_state = {lp_state, lp_state};
      m_ready_en = 1;
    end
  end

  always @(negedge clk) begin
    chk("cmp_count", fifo_count, q.size());
    chk("cmp_ready", in_ready, m_ready_en && (q.size() < DEPTH));
    chk("cmp_dvalid", ustrm_dvalid, exp_dvalid);
    chk("cmp_valid", ustrm_valid, exp_dvalid);
    chk("cmp_crc_valid", ustrm_crc_valid, exp_dvalid);
    chk("cmp_data", ustrm_data, exp_data);
    chk("cmp_crc", ustrm_crc, exp_crc);
    chk("cmp_protid", ustrm_protid, exp_protid);
    chk("cmp_state", ustrm_state, exp_state);
    chk("cmp_single", single_emit_cnt, exp_single);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [63:0] d, input logic [3:0] c, input logic [1:0] p);
    in_valid = 1'b1; in_data = d; in_crc = c; in_protid = p;
  endtask

  localparam logic [63:0] A = 64'hA1A1_0000_0000_000A;
  localparam logic [63:0] B = 64'hB2B2_0000_0000_000B;
  localparam logic [63:0] C = 64'hC3C3_0000_0000_000C;
  localparam logic [63:0] D = 64'hD4D4_0000_0000_000D;
  localparam logic [63:0] E = 64'hE5E5_0000_0000_000E;
  localparam logic [63:0] F = 64'hF6F6_0000_0000_000F;
  localparam logic [63:0] G = 64'h0707_0000_0000_0010;

  int k;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_dvalid", ustrm_dvalid, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("ready_after_release", in_ready, 1);
    link_up = 1'b1; lp_state = 4'h3;
    tick();

    // pair with equal protid
    drive(A, 4'h1, 2'd1); tick();
    drive(B, 4'h2, 2'd1); tick();
    in_valid = 1'b0; tick();
    chk("t1_dvalid", ustrm_dvalid, 2'b11);
    chk("t1_protid", ustrm_protid, 4'b0101);
    chk("t1_data", ustrm_data, {B, A});
    chk("t1_crc", ustrm_crc, 8'h21);
    chk("t1_count", fifo_count, 0);

    // lone entry released by the hold timeout
    drive(C, 4'h3, 2'd3); tick();
    in_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (k == 0 && ustrm_dvalid == 2'b01) k = i;
    end
    chk("t2_emit_cycle", k, 5);
    chk("t2_single", single_emit_cnt, 1);
    chk("t2_slot0", ustrm_data[63:0], C);
    chk("t2_slot1_held", ustrm_data[127:64], B);

    // protid change splits the pair
    lp_state = 4'h7;
    drive(D, 4'h4, 2'd0); tick();
    drive(E, 4'h5, 2'd2); tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("t3_single", single_emit_cnt, 3);
    chk("t3_slot0", ustrm_data[63:0], E);
    chk("t3_count", fifo_count, 0);

    // fill while link down, then drain as four pairs
    link_up = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(64'h4000 + 64'(i), 4'(i), 2'd2); tick();
    end
    chk("t4_full_count", fifo_count, 8);
    chk("t4_full_ready", in_ready, 0);
    chk("t4_no_output", ustrm_dvalid, 0);
    in_valid = 1'b0; link_up = 1'b1;
    tick();
    chk("t4_offline_edge", ustrm_dvalid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_pair_dvalid", ustrm_dvalid, 2'b11);
      chk("t4_pair_data", ustrm_data, {64'h4000 + 64'(2 * i + 1), 64'h4000 + 64'(2 * i)});
    end
    chk("t4_drained", fifo_count, 0);

    // full FIFO with in_valid held: one push, two pops per cycle
    link_up = 1'b0; lp_state = 4'h9;
    for (int i = 0; i < 9; i++) begin
      drive(64'h5000 + 64'(i), 4'(i), 2'd1); tick();
    end
    chk("t5_full", fifo_count, 8);
    link_up = 1'b1;
    drive(64'h5100, 4'hA, 2'd1); tick();
    chk("t5_c0", fifo_count, 8);
    for (int i = 1; i <= 4; i++) begin
      drive(64'h5100 + 64'(i), 4'hA, 2'd1); tick();
      chk("t5_drain", fifo_count, (i == 1) ? 6 : 7 - i);
    end
    for (int i = 5; i < 12; i++) begin
      drive(64'h5100 + 64'(i), 4'hB, 2'd1); tick();
    end

    // reset mid-burst
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dvalid", ustrm_dvalid, 0);
    chk("t6_rst_data", ustrm_data, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_single", single_emit_cnt, 0);
    chk("t6_rst_state", ustrm_state, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    drive(F, 4'hC, 2'd3); tick();
    drive(G, 4'hD, 2'd3); tick();
    in_valid = 1'b0; tick();
    chk("t6_dvalid", ustrm_dvalid, 2'b11);
    chk("t6_data", ustrm_data, {G, F});
    chk("t6_protid", ustrm_protid, 4'b1111);
    chk("t6_crc", ustrm_crc, 8'hDC);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
